// File: rtl/load_store_unit.sv
// Word-only data-memory load/store unit: sub-word loads are extracted and extended, sub-word
// stores use read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit #(
    parameter int unsigned DM_AW = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic [2:0]  dm_func3,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

    state_e           state_q;
    logic [DM_AW+1:0] addr_q;
    logic [2:0]       func3_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [31:0]      word_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             req_legal;
    logic             req_misal;
    logic             req_err;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_ext;
    logic [31:0]      merged;

    // Request classification, evaluated on the live request in IDLE.
    always_comb begin
        req_legal = req_we ? (req_func3 inside {3'b000, 3'b001, 3'b010})
                           : (req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        req_misal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_func3[1:0])
            2'b01:   req_misal = req_addr[0];
            2'b10:   req_misal = |req_addr[1:0];
            default: req_misal = 1'b0;
        endcase
`endif
        req_err = !req_legal || req_misal;
    end

    // Load lane selection; halves ignore addr[0] so misaligned halves truncate.
    always_comb begin
        ld_byte = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (func3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (func3_q[1:0])
            2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            func3_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[DM_AW+1:0];
                        func3_q <= req_func3;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= req_err;
                        if (req_err)                   state_q <= StResp;
                        else if (!req_we)              state_q <= StLoad;
                        else if (req_func3 == 3'b010)  state_q <= StWrite;
                        else                           state_q <= StRmwRd;
                    end
                end
                StLoad: begin
                    rdata_q <= ld_ext;
                    state_q <= StResp;
                end
                StRmwRd: begin
                    word_q  <= dm_rdata;
                    state_q <= StWrite;
                end
                StWrite: state_q <= StResp;
                StResp: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dm_rd      = (state_q == StLoad) || (state_q == StRmwRd);
    assign dm_wr      = (state_q == StWrite);
    assign dm_func3   = 3'b010;
    assign dm_addr    = {{(32 - DM_AW){1'b0}}, addr_q[DM_AW+1:2]};
    assign dm_wdata   = merged;

    logic unused_bits;
    assign unused_bits = ^{req_addr[31:DM_AW+2], we_q};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a response scoreboard.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_rd;
    logic        dm_wr;
    logic [2:0]  dm_func3;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:31];
    logic        bk_we = 1'b0;
    logic [4:0]  bk_idx = '0;
    logic [31:0] bk_data = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;
    exp_t sb[$];

    load_store_unit #(.DM_AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rd      (dm_rd),
        .dm_wr      (dm_wr),
        .dm_func3   (dm_func3),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[4:0]];

    always @(posedge clk) begin
        if (dm_wr) mem[dm_addr[4:0]] <= dm_wdata;
        else if (bk_we) mem[bk_idx] <= bk_data;
        if (dm_rd) rd_cnt <= rd_cnt + 1;
        if (dm_wr) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        bk_idx  = idx;
        bk_data = data;
        bk_we   = 1'b1;
        @(posedge clk);
        #1 bk_we = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the response cycle.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                          input int e_rd, input int e_wr, input bit hold);
        exp_t e;
        int   lat;
        int   rd0;
        int   wr0;
        e.rdata = e_rdata;
        e.err   = e_err;
        e.lat   = e_lat;
        e.rd    = e_rd;
        e.wr    = e_wr;
        sb.push_back(e);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        rd0       = rd_cnt;
        wr0       = wr_cnt;
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        if (hold) begin
            // A competing store kept valid while busy must be ignored.
            req_we    = 1'b1;
            req_func3 = 3'b010;
            req_addr  = 32'h18;
            req_wdata = 32'hFFFF_FFFF;
        end else begin
            req_valid = 1'b0;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 8);
        req_valid = 1'b0;
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " rdata"}, resp_rdata, e.rdata);
        check({tag, " err"}, 32'(resp_err), 32'(e.err));
        check({tag, " dm_rd cycles"}, 32'(rd_cnt - rd0), 32'(e.rd));
        check({tag, " dm_wr cycles"}, 32'(wr_cnt - wr0), 32'(e.wr));
        @(negedge clk);
        check({tag, " valid one cycle"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int seen;
        int wr0;
        preload(5'd0, 32'hA5A5_1234);
        preload(5'd2, 32'h1111_2222);
        preload(5'd3, 32'h8000_80F0);
        preload(5'd4, 32'h0000_0000);
        preload(5'd5, 32'h1122_3344);
        preload(5'd6, 32'h6666_6666);
        @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst dm_rd", 32'(dm_rd), 32'd0);
        check("rst dm_wr", 32'(dm_wr), 32'd0);
        check("dm_func3", 32'(dm_func3), 32'd2);
        rst_n = 1'b1;
        @(negedge clk);

        do_req("lb 0c",  1'b0, 3'b000, 32'h0C, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 1, 0, 1'b0);
        do_req("lhu 0e", 1'b0, 3'b101, 32'h0E, 32'h0, 32'h0000_8000, 1'b0, 2, 1, 0, 1'b0);
        do_req("lh 0e",  1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF_8000, 1'b0, 2, 1, 0, 1'b0);
        do_req("lbu 0d", 1'b0, 3'b100, 32'h0D, 32'h0, 32'h0000_0080, 1'b0, 2, 1, 0, 1'b0);
        do_req("lw 0c",  1'b0, 3'b010, 32'h0C, 32'h0, 32'h8000_80F0, 1'b0, 2, 1, 0, 1'b0);
        do_req("sb 15",  1'b1, 3'b000, 32'h15, 32'hAA, 32'h0, 1'b0, 3, 1, 1, 1'b0);
        check("sb word5", mem[5], 32'h1122_AA44);
        do_req("sh 16",  1'b1, 3'b001, 32'h16, 32'h1234_BEEF, 32'h0, 1'b0, 3, 1, 1, 1'b1);
        check("sh word5", mem[5], 32'hBEEF_AA44);
        check("busy req ignored", mem[6], 32'h6666_6666);
        do_req("sw 10",  1'b1, 3'b010, 32'h10, 32'h0BAD_F00D, 32'h0, 1'b0, 2, 0, 1, 1'b0);
        check("sw word4", mem[4], 32'h0BAD_F00D);
        do_req("ld f3 011", 1'b0, 3'b011, 32'h0C, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
        do_req("st f3 100", 1'b1, 3'b100, 32'h0C, 32'h55, 32'h0, 1'b1, 1, 0, 0, 1'b0);
        check("illegal store no write", mem[3], 32'h8000_80F0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw 02",  1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
        do_req("lh 0f",  1'b0, 3'b001, 32'h0F, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
`else
        do_req("lw 02",  1'b0, 3'b010, 32'h02, 32'h0, 32'hA5A5_1234, 1'b0, 2, 1, 0, 1'b0);
        do_req("lh 0f",  1'b0, 3'b001, 32'h0F, 32'h0, 32'hFFFF_8000, 1'b0, 2, 1, 0, 1'b0);
`endif

        // Reset while the SW to word 2 is in WRITE.
        wr0       = wr_cnt;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_func3 = 3'b010;
        req_addr  = 32'h08;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst-mid dm_wr before", 32'(dm_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst-mid dm_wr drop", 32'(dm_wr), 32'd0);
        check("rst-mid resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rst-mid no resp", 32'(seen), 32'd0);
        check("rst-mid word2", mem[2], 32'h1111_2222);
        check("rst-mid no write", 32'(wr_cnt - wr0), 32'd0);
        check("rst-mid ready", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DM_AW, default 5, word-address width of the data memory (2**DM_AW words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  core request valid.
REQ-005 SHALL have port req_ready  output  1  LSU accepts request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_func3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, sub-word data in low bits.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load data; 0 for stores.
REQ-012 SHALL have port resp_err  output  1  request failed, qualified by resp_valid.
REQ-013 SHALL have ports dm_addr (output 32), dm_wdata (output 32), dm_rd (output 1), dm_wr (output 1), dm_func3 (output 3), dm_rdata (input 32) to the data memory.

Function
REQ-014 SHALL always access memory as full words: dm_func3 = 3'b010, dm_addr = zero-extended req_addr[DM_AW+1:2].
REQ-015 SHALL implement FSM IDLE, LOAD, RMW_RD, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL latch addr/func3/we/wdata on req_valid & req_ready and leave IDLE: load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD; error -> RESP with err set.
REQ-017 SHALL assert dm_rd only in LOAD and RMW_RD; dm_wr only in WRITE; both decoded from registered state.
REQ-018 LOAD SHALL capture dm_rdata at the clock edge, select the byte/half by addr[1:0], and sign-extend (LB/LH) or zero-extend (LBU/LHU) into resp_rdata; then RESP.
REQ-019 RMW_RD SHALL capture dm_rdata; WRITE SHALL drive the captured word with only the addressed byte/half lanes replaced by req_wdata[7:0]/[15:0]; SW writes req_wdata unmodified.
REQ-020 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; no response backpressure.
REQ-021 Latency from accept edge to resp_valid cycle SHALL be: load 2, SW 2, SB/SH 3, error 1.
REQ-022 Illegal funct3 (loads 011/110/111; stores other than 000/001/010) SHALL give resp_err=1 with no dm_rd/dm_wr.
REQ-023 req_valid while not in IDLE SHALL be ignored with no state change.
REQ-024 Back-to-back: a request presented in the cycle after RESP SHALL be accepted (IDLE, ready=1).

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, dm_rd=0, dm_wr=0, clearing all latched request fields.
REQ-026 Reset mid-operation SHALL abort the operation: no write occurs after rst_n falls and no response is issued.

Configuration
REQ-027 With LSU_MISALIGN_TRAP_EN defined, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL complete as an error per REQ-016 with no memory access.
REQ-028 Without LSU_MISALIGN_TRAP_EN, misaligned addresses SHALL be truncated (half: addr[0] treated 0; word: addr[1:0] treated 0), the access proceeds, and resp_err is set only by REQ-022.

Verification
REQ-029 Word 3 = 32'h8000_80F0; LB addr 0x0C -> resp_rdata 32'hFFFF_FFF0, resp_valid 2 cycles after accept.
REQ-030 Same word; LHU addr 0x0E -> 32'h0000_8000; LH addr 0x0E -> 32'hFFFF_8000.
REQ-031 Word 5 = 32'h1122_3344; SB addr 0x15 data 0xAA -> word 5 = 32'h1122_AA44, dm_wr exactly one cycle, resp_valid 3 cycles after accept.
REQ-032 With macro: LW addr 0x02 -> resp_err=1 after 1 cycle, dm_rd/dm_wr never asserted; without macro: reads word 0, resp_err=0.
REQ-033 Assert rst_n low during WRITE of SW addr 0x08 data 0xDEADBEEF -> dm_wr drops immediately, word 2 unchanged, no resp_valid, req_ready=1 after reset release.
